// File: rtl/rv32_pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module   : rv32_pipeline_controller
// Purpose  : Central stall/flush/halt sequencer driving fetch, decode and exec.
//            Optional performance counters are built when RV32_PIPE_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_pipeline_controller (
    input  logic        clk,
    input  logic        resetn,
    input  logic        decode_stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        exec_busy,
    input  logic        mem_wait,
    input  logic        halt_req,
    input  logic        resume_req,
    input  logic        perf_clear,
    output logic        fetch_stop,
    output logic        fetch_set_pc,
    output logic [31:0] fetch_pc,
    output logic        decode_stop,
    output logic        decode_set_nop,
    output logic [31:0] decode_set_nop_pc,
    output logic        exec_stop,
    output logic        exec_set_nop,
    output logic        halted,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam logic [1:0] c_RUN     = 2'd0;
    localparam logic [1:0] c_FLUSH   = 2'd1;
    localparam logic [1:0] c_HALTING = 2'd2;
    localparam logic [1:0] c_HALTED  = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_target_q;
    logic [31:0] w_target_nxt;
    logic [1:0]  r_drain_cnt;
    logic [1:0]  w_drain_nxt;

    always_comb begin
        fetch_stop     = 1'b0;
        fetch_set_pc   = 1'b0;
        decode_stop    = 1'b0;
        decode_set_nop = 1'b0;
        exec_stop      = 1'b0;
        exec_set_nop   = 1'b0;
        halted         = 1'b0;
        w_state_nxt    = r_state;
        w_target_nxt   = r_target_q;
        w_drain_nxt    = r_drain_cnt;
        case (r_state)
            c_RUN: begin
                if (mem_wait) begin
                    fetch_stop  = 1'b1;
                    decode_stop = 1'b1;
                    exec_stop   = 1'b1;
                end else if (exec_busy) begin
                    fetch_stop   = 1'b1;
                    decode_stop  = 1'b1;
                    exec_set_nop = 1'b1;
                end else if (branch_taken) begin
                    fetch_set_pc   = 1'b1;
                    decode_set_nop = 1'b1;
                    w_target_nxt   = branch_target;
                    w_state_nxt    = c_FLUSH;
                end else if (halt_req) begin
                    fetch_stop     = 1'b1;
                    decode_set_nop = 1'b1;
                    w_drain_nxt    = 2'd2;
                    w_state_nxt    = c_HALTING;
                end else if (decode_stall) begin
                    fetch_stop = 1'b1;
                end
            end
            c_FLUSH: begin
                if (mem_wait) begin
                    fetch_stop  = 1'b1;
                    decode_stop = 1'b1;
                    exec_stop   = 1'b1;
                end else if (branch_taken) begin
                    // A second redirect restarts the one-cycle flush on the new path
                    fetch_set_pc   = 1'b1;
                    decode_set_nop = 1'b1;
                    w_target_nxt   = branch_target;
                end else begin
                    decode_set_nop = 1'b1;
                    w_state_nxt    = c_RUN;
                end
            end
            c_HALTING: begin
                fetch_stop     = 1'b1;
                decode_set_nop = 1'b1;
                if (mem_wait) begin
                    decode_stop = 1'b1;
                    exec_stop   = 1'b1;
                end else begin
                    if (branch_taken) begin
                        fetch_set_pc = 1'b1;
                        w_target_nxt = branch_target;
                    end
                    if (r_drain_cnt <= 2'd1) begin
                        w_drain_nxt = 2'd0;
                        w_state_nxt = c_HALTED;
                    end else begin
                        w_drain_nxt = r_drain_cnt - 2'd1;
                    end
                end
            end
            default: begin
                fetch_stop  = 1'b1;
                decode_stop = 1'b1;
                exec_stop   = 1'b1;
                halted      = 1'b1;
                if (resume_req) begin
                    w_state_nxt = c_RUN;
                end
            end
        endcase
    end

    assign fetch_pc          = branch_taken ? branch_target : r_target_q;
    assign decode_set_nop_pc = fetch_pc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= c_RUN;
            r_target_q  <= 32'd0;
            r_drain_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_target_q  <= w_target_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

`ifdef RV32_PIPE_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    // fetch_set_pc is asserted exactly when a redirect is accepted
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else if (perf_clear) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (fetch_stop && (r_state != c_HALTED) && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (fetch_set_pc && (r_flush_count != 32'hFFFF_FFFF)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    logic w_unused_perf_clear;
    assign w_unused_perf_clear = perf_clear;
    assign stall_cycles        = 32'd0;
    assign flush_count         = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv32_pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_pipeline_controller
// Purpose  : Scoreboard bench for rv32_pipeline_controller (honours RV32_PIPE_PERF_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_pipeline_controller;

    // stimulus bits
    localparam logic [7:0] c_I_DS  = 8'h01;
    localparam logic [7:0] c_I_BT  = 8'h02;
    localparam logic [7:0] c_I_EB  = 8'h04;
    localparam logic [7:0] c_I_MW  = 8'h08;
    localparam logic [7:0] c_I_HR  = 8'h10;
    localparam logic [7:0] c_I_RR  = 8'h20;
    localparam logic [7:0] c_I_PC  = 8'h40;
    localparam logic [7:0] c_I_RST = 8'h80;
    // expected control bits
    localparam logic [6:0] c_FS  = 7'h01;
    localparam logic [6:0] c_FSP = 7'h02;
    localparam logic [6:0] c_DS  = 7'h04;
    localparam logic [6:0] c_DSN = 7'h08;
    localparam logic [6:0] c_ES  = 7'h10;
    localparam logic [6:0] c_XN  = 7'h20;
    localparam logic [6:0] c_H   = 7'h40;
    localparam logic [6:0] c_HLT = c_FS | c_DS | c_ES | c_H;
    localparam logic [6:0] c_FRZ = c_FS | c_DS | c_ES;

    typedef struct packed {
        logic [7:0]  in;
        logic [6:0]  ctl;
        logic [31:0] pc;
    } item_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        decode_stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        exec_busy = 1'b0;
    logic        mem_wait = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume_req = 1'b0;
    logic        perf_clear = 1'b0;
    logic        fetch_stop, fetch_set_pc, decode_stop, decode_set_nop;
    logic        exec_stop, exec_set_nop, halted;
    logic [31:0] fetch_pc, decode_set_nop_pc, stall_cycles, flush_count;

    item_t       sb[$];
    item_t       r_it;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_step = 0;
    logic [31:0] m_stall = 32'd0;
    logic [31:0] m_flush = 32'd0;
    logic [31:0] w_exp_stall, w_exp_flush;

    rv32_pipeline_controller u_dut (
        .clk               (clk),
        .resetn            (resetn),
        .decode_stall      (decode_stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .exec_busy         (exec_busy),
        .mem_wait          (mem_wait),
        .halt_req          (halt_req),
        .resume_req        (resume_req),
        .perf_clear        (perf_clear),
        .fetch_stop        (fetch_stop),
        .fetch_set_pc      (fetch_set_pc),
        .fetch_pc          (fetch_pc),
        .decode_stop       (decode_stop),
        .decode_set_nop    (decode_set_nop),
        .decode_set_nop_pc (decode_set_nop_pc),
        .exec_stop         (exec_stop),
        .exec_set_nop      (exec_set_nop),
        .halted            (halted),
        .stall_cycles      (stall_cycles),
        .flush_count       (flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] in, input logic [31:0] tgt,
                        input logic [6:0] ctl, input logic [31:0] pc);
        @(posedge clk);
        #1;
        resetn        = ~in[7];
        decode_stall  = in[0];
        branch_taken  = in[1];
        exec_busy     = in[2];
        mem_wait      = in[3];
        halt_req      = in[4];
        resume_req    = in[5];
        perf_clear    = in[6];
        branch_target = tgt;
        sb.push_back({in, ctl, pc});
    endtask

    // Outputs checked mid-cycle; counters follow the expected controls of earlier cycles
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            r_it = sb.pop_front();
            n_step++;
            if (r_it.in[7]) begin
                m_stall = 32'd0;
                m_flush = 32'd0;
            end
`ifdef RV32_PIPE_PERF_EN
            w_exp_stall = m_stall;
            w_exp_flush = m_flush;
`else
            w_exp_stall = 32'd0;
            w_exp_flush = 32'd0;
`endif
            chk($sformatf("s%0d.ctl", n_step),
                {57'd0, halted, exec_set_nop, exec_stop, decode_set_nop, decode_stop, fetch_set_pc, fetch_stop},
                {57'd0, r_it.ctl});
            chk($sformatf("s%0d.fetch_pc", n_step), {32'd0, fetch_pc}, {32'd0, r_it.pc});
            chk($sformatf("s%0d.nop_pc", n_step), {32'd0, decode_set_nop_pc}, {32'd0, r_it.pc});
            chk($sformatf("s%0d.stall_cycles", n_step), {32'd0, stall_cycles}, {32'd0, w_exp_stall});
            chk($sformatf("s%0d.flush_count", n_step), {32'd0, flush_count}, {32'd0, w_exp_flush});
            if (!r_it.in[7]) begin
                if (r_it.in[6]) begin
                    m_stall = 32'd0;
                    m_flush = 32'd0;
                end else begin
                    if (r_it.ctl[0] && !r_it.ctl[6]) m_stall = m_stall + 32'd1;
                    if (r_it.ctl[1]) m_flush = m_flush + 32'd1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        step(c_I_RST, 32'h0, 7'h00, 32'h0);
        step(c_I_RST, 32'h0, 7'h00, 32'h0);
        step(8'h00,   32'h0, 7'h00, 32'h0);
        // load-use stall pulse
        step(c_I_DS,  32'h0, c_FS,  32'h0);
        step(8'h00,   32'h0, 7'h00, 32'h0);
        // redirect and flush
        step(c_I_BT,  32'h100, c_FSP | c_DSN, 32'h100);
        step(8'h00,   32'h0,   c_DSN,         32'h100);
        step(8'h00,   32'h0,   7'h00,         32'h100);
        // mem_wait dominates, then redirect taken once it drops
        step(c_I_MW | c_I_BT | c_I_EB, 32'h200, c_FRZ,         32'h200);
        step(c_I_BT,                   32'h200, c_FSP | c_DSN, 32'h200);
        step(8'h00,                    32'h0,   c_DSN,         32'h200);
        // exec_busy for 4 cycles after clearing the counters
        step(c_I_PC, 32'h0, 7'h00, 32'h200);
        for (int i = 0; i < 4; i++) step(c_I_EB, 32'h0, c_FS | c_DS | c_XN, 32'h200);
        step(8'h00, 32'h0, 7'h00, 32'h200);
        // back-to-back redirects restart the flush
        step(c_I_BT, 32'h300, c_FSP | c_DSN, 32'h300);
        step(c_I_BT, 32'h340, c_FSP | c_DSN, 32'h340);
        step(8'h00,  32'h0,   c_DSN,         32'h340);
        step(8'h00,  32'h0,   7'h00,         32'h340);
        // mem_wait holds FLUSH
        step(c_I_BT, 32'h400, c_FSP | c_DSN, 32'h400);
        step(c_I_MW, 32'h0,   c_FRZ,         32'h400);
        step(8'h00,  32'h0,   c_DSN,         32'h400);
        step(8'h00,  32'h0,   7'h00,         32'h400);
        // halt, resume with halt_req held, re-halt
        step(c_I_HR,          32'h0, c_FS | c_DSN, 32'h400);
        step(c_I_HR,          32'h0, c_FS | c_DSN, 32'h400);
        step(c_I_HR,          32'h0, c_FS | c_DSN, 32'h400);
        step(c_I_HR,          32'h0, c_HLT,        32'h400);
        step(c_I_HR,          32'h0, c_HLT,        32'h400);
        step(c_I_HR | c_I_RR, 32'h0, c_HLT,        32'h400);
        step(c_I_HR,          32'h0, c_FS | c_DSN, 32'h400);
        step(8'h00,           32'h0, c_FS | c_DSN, 32'h400);
        step(8'h00,           32'h0, c_FS | c_DSN, 32'h400);
        step(8'h00,           32'h0, c_HLT,        32'h400);
        step(c_I_RR,          32'h0, c_HLT,        32'h400);
        step(8'h00,           32'h0, 7'h00,        32'h400);
        // halt not accepted while exec_busy
        step(c_I_HR | c_I_EB, 32'h0, c_FS | c_DS | c_XN, 32'h400);
        step(8'h00,           32'h0, 7'h00,              32'h400);
        // redirect during HALTING keeps draining
        step(c_I_HR, 32'h0,   c_FS | c_DSN,         32'h400);
        step(c_I_BT, 32'h500, c_FS | c_FSP | c_DSN, 32'h500);
        step(8'h00,  32'h0,   c_FS | c_DSN,         32'h500);
        step(8'h00,  32'h0,   c_HLT,                32'h500);
        step(c_I_RR, 32'h0,   c_HLT,                32'h500);
        step(8'h00,  32'h0,   7'h00,                32'h500);
        // reset mid-HALTING aborts to RUN
        step(c_I_HR,  32'h0, c_FS | c_DSN, 32'h500);
        step(8'h00,   32'h0, c_FS | c_DSN, 32'h500);
        step(c_I_RST, 32'h0, 7'h00,        32'h0);
        step(8'h00,   32'h0, 7'h00,        32'h0);
        step(8'h00,   32'h0, 7'h00,        32'h0);
        // perf_clear wins over a concurrent increment
        step(c_I_DS,          32'h0, c_FS,  32'h0);
        step(c_I_DS | c_I_PC, 32'h0, c_FS,  32'h0);
        step(8'h00,           32'h0, 7'h00, 32'h0);
        step(8'h00,           32'h0, 7'h00, 32'h0);
        @(negedge clk);
        #1;
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32_pipeline_controller.md
# rv32_pipeline_controller

Central pipeline sequencer for the rv32 core. It turns per-stage status (load-use hazard from decode, redirect from exec, multi-cycle exec busy, data-memory wait, debug halt/resume) into the `stop`/`set_nop`/`set_pc` controls for fetch, decode and exec. Priority, flush length and halt draining are decided here and nowhere else. It sits beside the stage modules and is instantiated once in the core top.

## Interface
- No parameters.
- `clk` in 1: core clock.
- `resetn` in 1: asynchronous, active-low reset.
- `decode_stall` in 1: load-use hazard reported by decode; decode inserts its own bubble.
- `branch_taken` in 1: exec resolved a taken branch or jump this cycle.
- `branch_target` in 32: redirect PC; valid with `branch_taken`.
- `exec_busy` in 1: multi-cycle exec operation still in progress.
- `mem_wait` in 1: data memory not ready; the whole pipe must freeze.
- `halt_req` in 1: debug halt request, level.
- `resume_req` in 1: debug resume request, level.
- `perf_clear` in 1: synchronous clear of the performance counters.
- `fetch_stop` out 1: fetch holds its PC and buffer.
- `fetch_set_pc` out 1: fetch loads `fetch_pc`; has priority over `fetch_stop` inside fetch.
- `fetch_pc` out 32: redirect target.
- `decode_stop` out 1; `decode_set_nop` out 1; `decode_set_nop_pc` out 32.
- `exec_stop` out 1; `exec_set_nop` out 1.
- `halted` out 1: core is fully halted.
- `stall_cycles` out 32; `flush_count` out 32: performance counters (see Configuration).

## Operation
- Registered state: FSM `{RUN, FLUSH, HALTING, HALTED}`, `target_q`[31:0], `drain_cnt`[1:0], counters.
- All control outputs are combinational from the FSM state, `target_q` and the current inputs. Every output defaults to 0. `fetch_pc` = `branch_target` when `branch_taken`, else `target_q`. `decode_set_nop_pc` = `fetch_pc`.
- RUN, per-cycle priority (highest first):
  - `mem_wait`: `fetch_stop`=`decode_stop`=`exec_stop`=1. No state change. All other inputs are ignored this cycle.
  - `exec_busy`: `fetch_stop`=`decode_stop`=1, `exec_set_nop`=1 (bubble into mem).
  - `branch_taken`: `fetch_set_pc`=1, `decode_set_nop`=1. `target_q` ← `branch_target`. Next state FLUSH.
  - `halt_req`: `fetch_stop`=1, `decode_set_nop`=1. `drain_cnt` ← 2. Next state HALTING.
  - `decode_stall`: `fetch_stop`=1 only.
- FLUSH (exactly 1 cycle): `decode_set_nop`=1 with pc `target_q`, killing the in-flight wrong-path fetch. Next state RUN.
  - If `mem_wait` is high, all stops are asserted and FLUSH is held.
  - If `branch_taken` is high, it is handled as in RUN and FLUSH restarts with the new target.
- HALTING: `fetch_stop`=1, `decode_set_nop`=1. `drain_cnt` decrements when `mem_wait`=0. Enter HALTED when it reaches 0.
  - A `branch_taken` here asserts `fetch_set_pc` and updates `target_q`; draining continues.
- HALTED: `fetch_stop`=`decode_stop`=`exec_stop`=1, `halted`=1. `resume_req` → RUN next cycle. `halt_req` is ignored here.
- Reset (async): state RUN, `target_q`=0, `drain_cnt`=0, counters 0. With all inputs low, every output is 0.
- Reset asserted mid-FLUSH or mid-HALTING aborts immediately to RUN.

## Timing
- Inputs to controls: 0-cycle, combinational, same cycle.
- Redirect penalty: 2 bubbles (the branch cycle plus FLUSH).
- Halt: `halted` rises 3 cycles after `halt_req` is accepted, plus any `mem_wait` cycles.
- Resume: RUN in the cycle after `resume_req`.
- `halt_req` while `mem_wait` or `exec_busy` is high is not accepted until both are low.

## Configuration
- Macro `RV32_PIPE_PERF_EN`.
- Defined:
  - `stall_cycles` increments on every cycle with `fetch_stop`=1 and state ≠ HALTED.
  - `flush_count` increments on every accepted `branch_taken`.
  - Both saturate at 0xFFFFFFFF.
  - `perf_clear` zeroes both next edge and wins over increment.
- Undefined: ports stay in the interface; both outputs are tied to 0, `perf_clear` is ignored, and no counter flops exist.

## Test plan
- Reset, inputs low → all outputs 0, `halted`=0. Pulse `decode_stall` 1 cycle → only `fetch_stop`=1 that cycle.
- `branch_taken`=1, `branch_target`=0x0000_0100 → cycle 0: `fetch_set_pc`=1, `fetch_pc`=0x100, `decode_set_nop`=1; cycle 1: `decode_set_nop`=1, pc 0x100; cycle 2: all 0. With the macro, `flush_count`=1.
- `mem_wait`=1 together with `branch_taken` and `exec_busy` → all three stops high, no `set_pc`, state unchanged. Drop `mem_wait` next cycle with `branch_taken` still high → redirect taken.
- `exec_busy` high 4 cycles → `fetch_stop`/`decode_stop`/`exec_set_nop`=1 for exactly 4 cycles. With the macro, `stall_cycles`=4.
- `halt_req`=1 → `halted`=1 on cycle 3. Hold `halt_req` and pulse `resume_req` → RUN next cycle, then re-halts.
- Assert `resetn`=0 mid-HALTING → immediate RUN, `halted`=0; `perf_clear` during increment → counter reads 0.
